// File: rtl/mmu_load_sched_pkg.sv
// Shared state encoding and sizing constants for the MMU load scheduler.
// The optional loader timeout is enabled with MMU_LOAD_SCHED_TIMEOUT_EN.
package mmu_load_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_WAIT_W = 3'd2,
    ST_LOAD_D = 3'd3,
    ST_WAIT_D = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_NEXT   = 3'd6
  } sched_state_t;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int TIMEOUT_MULT       = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mmu_load_sched_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module sched_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mmu_load_sched.sv
// Sequences weight load, data load and array drain for each tile of a run.
// Define MMU_LOAD_SCHED_TIMEOUT_EN to add a sticky loader-timeout error.
module mmu_load_sched
  import mmu_load_sched_pkg::*;
#(
  parameter int fifo_width   = DEFAULT_FIFO_WIDTH,
  parameter int tile_width   = 8,
  parameter int drain_cycles = 2 * fifo_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [tile_width-1:0] num_tiles,
  input  logic                  weight_done,
  input  logic                  data_done,
  output logic                  weight_active,
  output logic                  weight_stagger,
  output logic                  data_active,
  output logic                  data_stagger,
  output logic                  busy,
  output logic [tile_width-1:0] tile_idx,
  output logic                  done,
  output logic                  error
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_MULT * fifo_width;
  localparam int CNT_W          = $clog2(max_int(drain_cycles, TIMEOUT_CYCLES) + 1);

  sched_state_t          state;
  logic                  arm;
  logic [tile_width-1:0] num_q;

  logic w_advance;
  logic d_advance;
  logic last_tile;
  logic drain_zero;
  logic timed_out;

  assign weight_stagger = 1'b0;
  assign data_stagger   = 1'b1;

  // Loader done idles high, so only a high seen after a low phase means finished.
  assign w_advance = (state == ST_WAIT_W) && weight_done && arm;
  assign d_advance = (state == ST_WAIT_D) && data_done && arm;
  assign last_tile = (tile_idx == (num_q - tile_width'(1)));

  sched_counter #(
    .WIDTH(CNT_W)
  ) u_drain_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (d_advance),
    .load_value(CNT_W'(drain_cycles - 1)),
    .dec       (state == ST_DRAIN),
    .zero      (drain_zero)
  );

`ifdef MMU_LOAD_SCHED_TIMEOUT_EN
  logic to_zero;

  sched_counter #(
    .WIDTH(CNT_W)
  ) u_timeout_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      ((state == ST_LOAD_W) || (state == ST_LOAD_D)),
    .load_value(CNT_W'(TIMEOUT_CYCLES - 1)),
    .dec       ((state == ST_WAIT_W) || (state == ST_WAIT_D)),
    .zero      (to_zero)
  );

  assign timed_out = to_zero &&
                     (((state == ST_WAIT_W) && !w_advance) ||
                      ((state == ST_WAIT_D) && !d_advance));

  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (timed_out) begin
      error <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

  // Outputs are registered, so each pulse is raised on the transition into its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      weight_active <= 1'b0;
      data_active   <= 1'b0;
      arm           <= 1'b0;
      tile_idx      <= '0;
      num_q         <= '0;
    end else begin
      weight_active <= 1'b0;
      data_active   <= 1'b0;
      done          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_tiles != '0) begin
              num_q         <= num_tiles;
              tile_idx      <= '0;
              busy          <= 1'b1;
              weight_active <= 1'b1;
              state         <= ST_LOAD_W;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_LOAD_W: begin
          arm   <= 1'b0;
          state <= ST_WAIT_W;
        end
        ST_WAIT_W: begin
          if (!weight_done) begin
            arm <= 1'b1;
          end
          if (w_advance) begin
            data_active <= 1'b1;
            state       <= ST_LOAD_D;
          end else if (timed_out) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_LOAD_D: begin
          arm   <= 1'b0;
          state <= ST_WAIT_D;
        end
        ST_WAIT_D: begin
          if (!data_done) begin
            arm <= 1'b1;
          end
          if (d_advance) begin
            state <= ST_DRAIN;
          end else if (timed_out) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_zero) begin
            done  <= last_tile;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_tile) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tile_idx      <= tile_idx + tile_width'(1);
            weight_active <= 1'b1;
            state         <= ST_LOAD_W;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_load_sched.sv
// Directed bench for mmu_load_sched with loader models and a tile/done scoreboard.
// Build with MMU_LOAD_SCHED_TIMEOUT_EN to exercise the timeout path.
module tb_mmu_load_sched;

  localparam int FW = 16;
  localparam int TW = 8;
  localparam int WAIT_TO_DATA   = 18;
  localparam int DATA_TO_DONE   = 18 + 2 * FW;
  localparam int DATA_TO_NEXT_W = DATA_TO_DONE + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic          weight_done = 1'b1;
  logic          data_done = 1'b1;
  logic          weight_active, weight_stagger, data_active, data_stagger;
  logic          busy, done, error;
  logic [TW-1:0] tile_idx;

  int compare_count = 0;
  int fail_count = 0;
  int cyc = 0;
  int w_pulses = 0;
  int d_pulses = 0;
  int last_w_cyc = 0;
  int last_d_cyc = 0;
  int w_timer = 0;
  int d_timer = 0;
  bit stuck_w = 1'b0;
  int mon_t;
  int exp_tile[$];
  int exp_done[$];

  mmu_load_sched #(
    .fifo_width  (FW),
    .tile_width  (TW),
    .drain_cycles(2 * FW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_tiles     (num_tiles),
    .weight_done   (weight_done),
    .data_done     (data_done),
    .weight_active (weight_active),
    .weight_stagger(weight_stagger),
    .data_active   (data_active),
    .data_stagger  (data_stagger),
    .busy          (busy),
    .tile_idx      (tile_idx),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Loader models: done drops the cycle after activate and stays low for FW cycles.
  always @(negedge clk) begin
    if (reset) begin
      w_timer = 0;
      d_timer = 0;
      weight_done = 1'b1;
      data_done = 1'b1;
    end else begin
      if (weight_active) w_timer = FW + 1;
      else if (w_timer > 0) w_timer--;
      if (data_active) d_timer = FW + 1;
      else if (d_timer > 0) d_timer--;
      weight_done = stuck_w || !(w_timer > 0 && w_timer <= FW);
      data_done = !(d_timer > 0 && d_timer <= FW);
    end
  end

  // Scoreboard monitor: pops expected tile indices and done tokens as the DUT emits them.
  always @(negedge clk) begin
    if (!reset) begin
      if (weight_active || data_active)
        checkOutput("no_overlap", 32'(weight_active & data_active), 0);
      if (weight_active) begin
        w_pulses++;
        checkOutput("w_expected", 32'(exp_tile.size() != 0), 1);
        if (exp_tile.size() != 0) begin
          mon_t = exp_tile.pop_front();
          checkOutput("tile_idx_at_w", 32'(tile_idx), mon_t);
          if (mon_t != 0) checkOutput("next_to_w_gap", cyc - last_d_cyc, DATA_TO_NEXT_W);
        end
        last_w_cyc = cyc;
      end
      if (data_active) begin
        d_pulses++;
        checkOutput("w_to_d_gap", cyc - last_w_cyc, WAIT_TO_DATA);
        last_d_cyc = cyc;
      end
      if (done) begin
        checkOutput("done_expected", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          mon_t = exp_done.pop_front();
          if (mon_t >= 0) begin
            checkOutput("tile_idx_at_done", 32'(tile_idx), mon_t);
            checkOutput("d_to_done_gap", cyc - last_d_cyc, DATA_TO_DONE);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) exp_tile.push_back(i);
    exp_done.push_back(n - 1);
    @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(n);
    @(negedge clk);
    start = 1'b0;
    num_tiles = '0;
  endtask

  task automatic waitDone(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_within_bound", 32'(seen), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    exp_tile.delete();
    exp_done.delete();
    @(negedge clk);
  endtask

  initial begin
    int w0, d0;
    bit seen;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_error", 32'(error), 0);
    checkOutput("rst_w_active", 32'(weight_active), 0);
    checkOutput("rst_d_active", 32'(data_active), 0);
    checkOutput("rst_tile_idx", 32'(tile_idx), 0);
    checkOutput("w_stagger", 32'(weight_stagger), 0);
    checkOutput("d_stagger", 32'(data_stagger), 1);
    reset = 1'b0;

    $display("[TB] single tile");
    w0 = w_pulses; d0 = d_pulses;
    applyStimulus(1);
    checkOutput("busy_after_start", 32'(busy), 1);
    waitDone(200);
    checkOutput("busy_during_done", 32'(busy), 1);
    @(negedge clk);
    checkOutput("busy_after_done", 32'(busy), 0);
    checkOutput("done_single_pulse", 32'(done), 0);
    checkOutput("single_w_count", w_pulses - w0, 1);
    checkOutput("single_d_count", d_pulses - d0, 1);

    $display("[TB] three tiles with stray start in WAIT_D");
    w0 = w_pulses; d0 = d_pulses;
    applyStimulus(3);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (d_pulses != d0) seen = 1'b1;
    end
    checkOutput("first_d_within_bound", 32'(seen), 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    num_tiles = TW'(5);
    @(negedge clk);
    start = 1'b0;
    num_tiles = '0;
    waitDone(400);
    @(negedge clk);
    checkOutput("multi_busy_after_done", 32'(busy), 0);
    checkOutput("multi_w_count", w_pulses - w0, 3);
    checkOutput("multi_d_count", d_pulses - d0, 3);
    repeat (5) @(negedge clk);
    checkOutput("stray_start_not_queued", 32'(busy), 0);
    checkOutput("stray_no_extra_w", w_pulses - w0, 3);

    $display("[TB] zero tiles");
    w0 = w_pulses; d0 = d_pulses;
    exp_done.push_back(-1);
    @(negedge clk);
    start = 1'b1;
    num_tiles = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_busy", 32'(busy), 0);
    @(negedge clk);
    checkOutput("zero_done_one_cycle", 32'(done), 0);
    checkOutput("zero_busy_stays", 32'(busy), 0);
    checkOutput("zero_no_activates", (w_pulses - w0) + (d_pulses - d0), 0);

    $display("[TB] reset during DRAIN of tile 1");
    d0 = d_pulses;
    applyStimulus(3);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (d_pulses - d0 == 2) seen = 1'b1;
    end
    checkOutput("tile1_d_within_bound", 32'(seen), 1);
    repeat (20) @(negedge clk);
    checkOutput("in_drain_busy", 32'(busy), 1);
    checkOutput("in_drain_tile_idx", 32'(tile_idx), 1);
    doReset();
    checkOutput("midrun_rst_busy", 32'(busy), 0);
    checkOutput("midrun_rst_tile_idx", 32'(tile_idx), 0);
    reset = 1'b0;
    w0 = w_pulses; d0 = d_pulses;
    applyStimulus(2);
    waitDone(300);
    checkOutput("after_rst_w_count", w_pulses - w0, 2);
    checkOutput("after_rst_d_count", d_pulses - d0, 2);

    $display("[TB] weight done stuck high");
    @(negedge clk);
    stuck_w = 1'b1;
    d0 = d_pulses;
    applyStimulus(1);
    exp_done.delete();
    exp_done.push_back(-1);
`ifdef MMU_LOAD_SCHED_TIMEOUT_EN
    waitDone(4 * FW + 10);
    checkOutput("timeout_error", 32'(error), 1);
    checkOutput("timeout_busy", 32'(busy), 0);
`else
    repeat (100) @(negedge clk);
    checkOutput("stuck_busy", 32'(busy), 1);
    checkOutput("stuck_error", 32'(error), 0);
`endif
    checkOutput("stuck_no_data_active", d_pulses - d0, 0);
    stuck_w = 1'b0;
    doReset();
    checkOutput("final_rst_error", 32'(error), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mmu_load_sched.md
MMU_LOAD_SCHED -- requirements
Module: mmu_load_sched

Interface
REQ-001 Parameter fifo_width, default 16: systolic array dimension; FIFO lanes per loader.
REQ-002 Parameter tile_width, default 8: width of the tile-count input.
REQ-003 Parameter drain_cycles, default 2*fifo_width: cycles the array needs to drain results after a data load.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a run; sampled only in IDLE.
REQ-007 num_tiles  input  tile_width  tiles to process; captured with start.
REQ-008 weight_done  input  1  done level from the weight FIFO loader.
REQ-009 data_done  input  1  done level from the data FIFO loader.
REQ-010 weight_active  output  1  one-cycle activate pulse to the weight loader.
REQ-011 weight_stagger  output  1  stagger-mode select for the weight loader; constant 0.
REQ-012 data_active  output  1  one-cycle activate pulse to the data loader.
REQ-013 data_stagger  output  1  stagger-mode select for the data loader; constant 1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 tile_idx  output  tile_width  index of the tile currently in process.
REQ-016 done  output  1  one-cycle pulse when the last tile finishes draining.
REQ-017 error  output  1  sticky loader-timeout flag (see Configuration).

Function
REQ-018 States: IDLE, LOAD_W, WAIT_W, LOAD_D, WAIT_D, DRAIN, NEXT. All outputs are registered.
REQ-019 IDLE: start=1 with num_tiles!=0 -> capture num_tiles, clear tile_idx, go to LOAD_W. start with num_tiles=0 -> pulse done on the next cycle and stay in IDLE.
REQ-020 LOAD_W: weight_active=1 for exactly one cycle, clear the arm flag, then go to WAIT_W.
REQ-021 Loader done is a level that already reads high while the loader is idle. Handling in WAIT_W and WAIT_D:
  - set the arm flag on the first cycle done is sampled low;
  - advance only when done=1 and the arm flag is set.
REQ-022 WAIT_W -> LOAD_D. LOAD_D: data_active=1 for exactly one cycle, clear the arm flag, then go to WAIT_D.
REQ-023 WAIT_D -> DRAIN. DRAIN loads a down-counter with drain_cycles-1 and holds until the counter reaches 0, giving exactly drain_cycles cycles in DRAIN.
REQ-024 NEXT, when tile_idx==num_tiles-1: done=1 for one cycle, go to IDLE.
REQ-025 NEXT, otherwise: increment tile_idx, go to LOAD_W. NEXT lasts exactly one cycle in both cases.
REQ-026 start while busy is ignored and does not queue a request.
REQ-027 weight_active and data_active are never high in the same cycle.
REQ-028 tile_idx increments without wrap: num_tiles is at most 2^tile_width-1, so the final index is num_tiles-1.

Reset
REQ-029 Reset values: state=IDLE; busy, done, error, weight_active, data_active, arm flag and tile_idx all 0. Reset takes effect from any state, including mid-run.
REQ-030 Reset overrides start when both are asserted in the same cycle.

Configuration
REQ-031 Macro MMU_LOAD_SCHED_TIMEOUT_EN defined:
  - a timeout counter runs in WAIT_W and WAIT_D;
  - if 4*fifo_width cycles pass without advancing, set error (sticky until reset), pulse done and go to IDLE.
REQ-032 MMU_LOAD_SCHED_TIMEOUT_EN undefined: no timeout counter; error is tied to 0; WAIT states wait indefinitely.

Structure
REQ-033 A shared package holds the state encoding constants, the default fifo_width, and the timeout multiplier (4).
REQ-034 One sub-module, sched_counter: a loadable down-counter with a zero flag. It is used for DRAIN and, when enabled, for the timeout.

Verification
REQ-035 Single tile, fifo_width=16:
  - num_tiles=1, start; each loader model drops done 1 cycle after its activate and raises it 16 cycles later;
  - required: weight_active then data_active, 32 DRAIN cycles, a single done pulse, busy falls the cycle after done.
REQ-036 num_tiles=3 -> tile_idx steps 0,1,2; exactly 3 weight_active and 3 data_active pulses, never coincident; done pulses once.
REQ-037 Loader done held high with no low phase -> scheduler stays in WAIT_W, no data_active; with TIMEOUT_EN, error=1 after 64 cycles and done pulses.
REQ-038 num_tiles=0 with start -> done pulses one cycle later, busy stays 0, no activate pulses.
REQ-039 Reset asserted in DRAIN on tile 1 of 3 -> next cycle state IDLE with busy=0 and tile_idx=0; a new start runs normally.
REQ-040 start pulsed during WAIT_D -> ignored; total activate pulses still equal 2*num_tiles.
